// File: rtl/phys_reg_file.sv
// phys_reg_file: physical register file with per-register ready bits.
// Two combinational read ports, two writeback ports, one allocate port.
// Register 0 is hardwired to zero and is always ready.
// Optional macro PRF_WB_BYPASS_EN forwards same-cycle writeback data to the read ports.
module phys_reg_file #(
   parameter int unsigned NUM_PREGS = 64,
   parameter int unsigned XLEN      = 32,
   parameter int unsigned IW        = $clog2(NUM_PREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [IW-1:0]   src1_index,
   output logic [XLEN-1:0] src1_val,
   output logic            src1_ready,
   input  logic [IW-1:0]   src2_index,
   output logic [XLEN-1:0] src2_val,
   output logic            src2_ready,
   input  logic            wb0_valid,
   input  logic [IW-1:0]   wb0_index,
   input  logic [XLEN-1:0] wb0_val,
   input  logic            wb1_valid,
   input  logic [IW-1:0]   wb1_index,
   input  logic [XLEN-1:0] wb1_val,
   input  logic            alloc_valid,
   input  logic [IW-1:0]   alloc_index
);

   logic [XLEN-1:0] regs [NUM_PREGS];
   logic            rdy  [NUM_PREGS];

   logic wb0_en;
   logic wb1_en;
   logic alloc_en;

   // Strobes aimed at the zero register are dropped.
   always_comb begin
      wb0_en   = wb0_valid   && (wb0_index   != '0);
      wb1_en   = wb1_valid   && (wb1_index   != '0);
      alloc_en = alloc_valid && (alloc_index != '0);
   end

   // State update: wb1 is applied after wb0 so it wins on a shared index;
   // alloc is applied last so the ready bit ends at 0 when it collides with a writeback.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_PREGS; i++) begin
            regs[i] <= '0;
            rdy[i]  <= 1'b1;
         end
      end else begin
         if (wb0_en) begin
            regs[wb0_index] <= wb0_val;
            rdy[wb0_index]  <= 1'b1;
         end
         if (wb1_en) begin
            regs[wb1_index] <= wb1_val;
            rdy[wb1_index]  <= 1'b1;
         end
         if (alloc_en) begin
            rdy[alloc_index] <= 1'b0;
         end
      end
   end

   // Read port 1: stored state, optional writeback forwarding, zero register forced.
   always_comb begin
      src1_val   = regs[src1_index];
      src1_ready = rdy[src1_index];
`ifdef PRF_WB_BYPASS_EN
      // Bypass is suppressed during reset so reads show the cleared state.
      if (!rst && wb1_en && (wb1_index == src1_index)) begin
         src1_val   = wb1_val;
         src1_ready = 1'b1;
      end else if (!rst && wb0_en && (wb0_index == src1_index)) begin
         src1_val   = wb0_val;
         src1_ready = 1'b1;
      end
`endif
      if (src1_index == '0) begin
         src1_val   = '0;
         src1_ready = 1'b1;
      end
   end

   // Read port 2: same structure as read port 1.
   always_comb begin
      src2_val   = regs[src2_index];
      src2_ready = rdy[src2_index];
`ifdef PRF_WB_BYPASS_EN
      if (!rst && wb1_en && (wb1_index == src2_index)) begin
         src2_val   = wb1_val;
         src2_ready = 1'b1;
      end else if (!rst && wb0_en && (wb0_index == src2_index)) begin
         src2_val   = wb0_val;
         src2_ready = 1'b1;
      end
`endif
      if (src2_index == '0) begin
         src2_val   = '0;
         src2_ready = 1'b1;
      end
   end

endmodule

// File: tb/tb_phys_reg_file.sv
// tb_phys_reg_file: directed self-checking bench for phys_reg_file.
// Expectations follow PRF_WB_BYPASS_EN when it is defined for the build.
module tb_phys_reg_file;

   localparam int unsigned NUM_PREGS = 64;
   localparam int unsigned XLEN      = 32;
   localparam int unsigned IW        = 6;

   logic            clk;
   logic            rst;
   logic [IW-1:0]   src1_index;
   logic [XLEN-1:0] src1_val;
   logic            src1_ready;
   logic [IW-1:0]   src2_index;
   logic [XLEN-1:0] src2_val;
   logic            src2_ready;
   logic            wb0_valid;
   logic [IW-1:0]   wb0_index;
   logic [XLEN-1:0] wb0_val;
   logic            wb1_valid;
   logic [IW-1:0]   wb1_index;
   logic [XLEN-1:0] wb1_val;
   logic            alloc_valid;
   logic [IW-1:0]   alloc_index;

   int vectors;
   int miscompares;

   phys_reg_file #(.NUM_PREGS(NUM_PREGS), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst),
      .src1_index(src1_index), .src1_val(src1_val), .src1_ready(src1_ready),
      .src2_index(src2_index), .src2_val(src2_val), .src2_ready(src2_ready),
      .wb0_valid(wb0_valid), .wb0_index(wb0_index), .wb0_val(wb0_val),
      .wb1_valid(wb1_valid), .wb1_index(wb1_index), .wb1_val(wb1_val),
      .alloc_valid(alloc_valid), .alloc_index(alloc_index)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef PRF_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb0_valid = 1'b0; wb1_valid = 1'b0; alloc_valid = 1'b0;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      src1_index = '0; src2_index = '0;
      wb0_valid = 1'b0; wb0_index = '0; wb0_val = '0;
      wb1_valid = 1'b0; wb1_index = '0; wb1_val = '0;
      alloc_valid = 1'b0; alloc_index = '0;

      // Reset state
      #2;
      src1_index = 6'd5; src2_index = 6'd63;
      #1;
      chk("rst_val5", src1_val, 32'h0);
      chk("rst_rdy5", {31'b0, src1_ready}, 32'h1);
      chk("rst_val63", src2_val, 32'h0);
      step();
      rst = 1'b0;

      // Basic write/read through wb0
      wb0_valid = 1'b1; wb0_index = 6'd7; wb0_val = 32'h12345678;
      src1_index = 6'd7; src2_index = 6'd7;
      #1;
      chk("wr7_same_cycle", src1_val, BYP ? 32'h12345678 : 32'h0);
      step();
      idle();
      #1;
      chk("wr7_src1_val", src1_val, 32'h12345678);
      chk("wr7_src1_rdy", {31'b0, src1_ready}, 32'h1);
      chk("wr7_src2_val", src2_val, 32'h12345678);

      // Zero register: writes and alloc ignored
      wb1_valid = 1'b1; wb1_index = 6'd0; wb1_val = 32'hFFFFFFFF;
      alloc_valid = 1'b1; alloc_index = 6'd0;
      src1_index = 6'd0;
      #1;
      chk("zero_same_val", src1_val, 32'h0);
      step();
      idle();
      #1;
      chk("zero_next_val", src1_val, 32'h0);
      chk("zero_next_rdy", {31'b0, src1_ready}, 32'h1);
      step();
      chk("zero_later_val", src1_val, 32'h0);
      chk("zero_later_rdy", {31'b0, src1_ready}, 32'h1);

      // Same-index writeback conflict: wb1 wins
      wb0_valid = 1'b1; wb0_index = 6'd9; wb0_val = 32'hAAAA0000;
      wb1_valid = 1'b1; wb1_index = 6'd9; wb1_val = 32'h0000BBBB;
      src1_index = 6'd9;
      #1;
      chk("conf_same_cycle", src1_val, BYP ? 32'h0000BBBB : 32'h0);
      step();
      idle();
      #1;
      chk("conf_val9", src1_val, 32'h0000BBBB);
      chk("conf_rdy9", {31'b0, src1_ready}, 32'h1);

      // Alloc vs writeback on 12, plus wb1 to a distinct index in parallel
      alloc_valid = 1'b1; alloc_index = 6'd12;
      wb0_valid = 1'b1; wb0_index = 6'd12; wb0_val = 32'h55;
      wb1_valid = 1'b1; wb1_index = 6'd13; wb1_val = 32'h77;
      step();
      idle();
      src1_index = 6'd12; src2_index = 6'd13;
      #1;
      chk("alwb_val12", src1_val, 32'h55);
      chk("alwb_rdy12", {31'b0, src1_ready}, 32'h0);
      chk("par_val13", src2_val, 32'h77);
      chk("par_rdy13", {31'b0, src2_ready}, 32'h1);
      wb0_valid = 1'b1; wb0_index = 6'd12; wb0_val = 32'h66;
      step();
      idle();
      #1;
      chk("rewb_val12", src1_val, 32'h66);
      chk("rewb_rdy12", {31'b0, src1_ready}, 32'h1);

      // Alloc alone leaves data intact
      alloc_valid = 1'b1; alloc_index = 6'd7;
      src1_index = 6'd7;
      step();
      idle();
      #1;
      chk("alloc7_val", src1_val, 32'h12345678);
      chk("alloc7_rdy", {31'b0, src1_ready}, 32'h0);

      // Bypass on read port 2
      wb0_valid = 1'b1; wb0_index = 6'd20; wb0_val = 32'hCAFEF00D;
      src2_index = 6'd20;
      #1;
      chk("byp_same_val", src2_val, BYP ? 32'hCAFEF00D : 32'h0);
      chk("byp_same_rdy", {31'b0, src2_ready}, 32'h1);
      step();
      idle();
      #1;
      chk("byp_next_val", src2_val, 32'hCAFEF00D);

      // Same-cycle alloc does not change read outputs until the edge
      alloc_valid = 1'b1; alloc_index = 6'd20;
      #1;
      chk("alloc_same_rdy", {31'b0, src2_ready}, 32'h1);
      step();
      idle();
      #1;
      chk("alloc_next_rdy", {31'b0, src2_ready}, 32'h0);

      // Bypass priority: wb1 over wb0 on the same read index; ready overrides alloc-cleared bit
      wb0_valid = 1'b1; wb0_index = 6'd7; wb0_val = 32'h1;
      wb1_valid = 1'b1; wb1_index = 6'd7; wb1_val = 32'h2;
      src1_index = 6'd7;
      #1;
      chk("bprio_val", src1_val, BYP ? 32'h2 : 32'h12345678);
      chk("bprio_rdy", {31'b0, src1_ready}, BYP ? 32'h1 : 32'h0);
      step();
      idle();
      #1;
      chk("bprio_next_val", src1_val, 32'h2);

      // Asynchronous reset mid-run
      wb0_valid = 1'b1; wb0_index = 6'd5; wb0_val = 32'hDEADBEEF;
      step();
      idle();
      src1_index = 6'd5; src2_index = 6'd12;
      #1;
      chk("pre_rst_val5", src1_val, 32'hDEADBEEF);
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst_val5", src1_val, 32'h0);
      chk("async_rst_rdy5", {31'b0, src1_ready}, 32'h1);
      chk("async_rst_val12", src2_val, 32'h0);
      wb0_valid = 1'b1; wb0_index = 6'd5; wb0_val = 32'h11;
      alloc_valid = 1'b1; alloc_index = 6'd12;
      #1;
      chk("rst_nobyp_val5", src1_val, 32'h0);
      step();
      chk("rst_wb_ignored", src1_val, 32'h0);
      chk("rst_alloc_ignored", {31'b0, src2_ready}, 32'h1);
      idle();
      rst = 1'b0;
      step();
      chk("post_rst_val5", src1_val, 32'h0);
      chk("post_rst_rdy5", {31'b0, src1_ready}, 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
